// File: rtl/farbwechsel_pkg.sv
// Shared definitions for the colour-cycling generator: mode encodings and
// prescaler counter sizing.
package farbwechsel_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_PP   = 2'b10,
        MODE_DOWN = 2'b11
    } mode_e;

    // Width of a counter that must reach div-1; never narrower than one bit.
    function automatic int presc_cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/farbwechsel_teiler.sv
// Step prescaler: counts 0..T-1 and requests an advance at T-1, where T
// follows the turbo select. Held at 0 while disabled, cleared by clr.
module farbwechsel_teiler
    import farbwechsel_pkg::*;
#(
    parameter int DIV_NORM  = 25_000_000,
    parameter int DIV_TURBO = 2_500_000,
    parameter int CNT_W     = presc_cnt_w(DIV_NORM)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic turbo,
    input  logic clr,
    input  logic en,
    output logic req
);

    localparam logic [CNT_W-1:0] LAST_N = CNT_W'(DIV_NORM - 1);
    localparam logic [CNT_W-1:0] LAST_T = CNT_W'(DIV_TURBO - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last;

    // ">=" rather than "==" catches a count already past the end after a
    // switch to the shorter turbo period: one request, then wrap.
    always_comb begin
        last  = turbo ? LAST_T : LAST_N;
        req   = en && (cnt_q >= last);
        cnt_d = cnt_q + CNT_W'(1);
        if (!en || clr || req) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/farbwechsel_gen.sv
// Colour-cycling generator: steps an index through a writable palette in
// hold/up/ping-pong/down modes and presents the selected colour.
module farbwechsel_gen
    import farbwechsel_pkg::*;
#(
    parameter int CH_W      = 1,
    parameter int N_COL     = 8,
    parameter int DIV_NORM  = 25_000_000,
    parameter int DIV_TURBO = 2_500_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              turbo,
    input  logic [1:0]        mode,
    input  logic              step,
    input  logic              wr_en,
    input  logic [7:0]        wr_addr,
    input  logic [3*CH_W-1:0] wr_data,
    output logic [3*CH_W-1:0] rgb,
    output logic [7:0]        idx,
    output logic              tick
);

    localparam int         PIX_W    = 3 * CH_W;
    localparam logic [7:0] LAST_IDX = 8'(N_COL - 1);

    mode_e            md;
    logic             pre_req;
    logic             adv;
    logic             go_up;
    logic [7:0]       idx_q, idx_d;
    logic             dir_up_q, dir_up_d;
    logic             tick_q, tick_d;
    logic [PIX_W-1:0] rgb_q, rgb_d;
    logic [PIX_W-1:0] pal_q [N_COL];
    logic [PIX_W-1:0] pal_d [N_COL];

    assign md = mode_e'(mode);

    farbwechsel_teiler #(
        .DIV_NORM  (DIV_NORM),
        .DIV_TURBO (DIV_TURBO)
    ) u_teiler (
        .clk   (clk),
        .rst_n (rst_n),
        .turbo (turbo),
        .clr   (step),
        .en    (md != MODE_HOLD),
        .req   (pre_req)
    );

    assign adv    = step || pre_req;
    assign tick_d = adv;

    // Ping-pong turns around at the ends within the same advance, so the
    // end entry is shown once (6,7,6,5).
    always_comb begin
        idx_d    = idx_q;
        dir_up_d = dir_up_q;
        case (md)
            MODE_DOWN: go_up = 1'b0;
            MODE_PP:   go_up = dir_up_q;
            default:   go_up = 1'b1;
        endcase
        if (adv && N_COL > 1) begin
            if (md == MODE_PP && dir_up_q && idx_q == LAST_IDX) begin
                dir_up_d = 1'b0;
                go_up    = 1'b0;
            end else if (md == MODE_PP && !dir_up_q && idx_q == 8'd0) begin
                dir_up_d = 1'b1;
                go_up    = 1'b1;
            end
            if (go_up) idx_d = (idx_q == LAST_IDX) ? 8'd0 : idx_q + 8'd1;
            else       idx_d = (idx_q == 8'd0) ? LAST_IDX : idx_q - 8'd1;
        end
    end

    // Out-of-range addresses match no entry and fall through untouched.
    always_comb begin
        pal_d = pal_q;
        for (int i = 0; i < N_COL; i++) begin
            if (wr_en && wr_addr == 8'(i)) pal_d[i] = wr_data;
        end
    end

    // Reading the post-write array gives write-through on the same edge.
    always_comb begin
        rgb_d = '0;
        for (int i = 0; i < N_COL; i++) begin
            if (idx_d == 8'(i)) rgb_d = pal_d[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= 8'd0;
            dir_up_q <= 1'b1;
            tick_q   <= 1'b0;
            rgb_q    <= '0;
            for (int i = 0; i < N_COL; i++) pal_q[i] <= PIX_W'(i);
        end else begin
            idx_q    <= idx_d;
            dir_up_q <= dir_up_d;
            tick_q   <= tick_d;
            rgb_q    <= rgb_d;
            pal_q    <= pal_d;
        end
    end

    assign idx  = idx_q;
    assign rgb  = rgb_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_farbwechsel_gen.sv
// Scoreboard bench: the driver pushes the expected per-cycle output of a
// behavioural model, the monitor pops and compares after each rising edge.
module tb_farbwechsel_gen;

    localparam int DN = 4;
    localparam int DT = 2;

    typedef struct packed {
        int              cnt;
        int              idx;
        bit              dir_up;
        logic [7:0][2:0] pal;
        logic [2:0]      rgb;
        bit              tick;
    } model_t;

    logic       clk = 1'b0;
    logic       rst_n, turbo, step, wr_en;
    logic [1:0] mode;
    logic [7:0] wr_addr;
    logic [2:0] wr_data;
    logic [2:0] rgb8, rgb1;
    logic [7:0] idx8, idx1;
    logic       tick8, tick1;

    int     nvec = 0;
    int     nerr = 0;
    model_t m8, m1;
    model_t q8[$];
    model_t q1[$];

    always #5 clk = ~clk;

    farbwechsel_gen #(.CH_W(1), .N_COL(8), .DIV_NORM(DN), .DIV_TURBO(DT)) dut8 (
        .clk(clk), .rst_n(rst_n), .turbo(turbo), .mode(mode), .step(step),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rgb(rgb8), .idx(idx8), .tick(tick8)
    );

    farbwechsel_gen #(.CH_W(1), .N_COL(1), .DIV_NORM(DN), .DIV_TURBO(DT)) dut1 (
        .clk(clk), .rst_n(rst_n), .turbo(turbo), .mode(mode), .step(step),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rgb(rgb1), .idx(idx1), .tick(tick1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic model_t mreset();
        model_t m;
        m.cnt    = 0;
        m.idx    = 0;
        m.dir_up = 1'b1;
        for (int i = 0; i < 8; i++) m.pal[i] = 3'(i);
        m.rgb    = 3'd0;
        m.tick   = 1'b0;
        return m;
    endfunction

    // One clock of the colour sequencer, from the rules stated in words.
    function automatic model_t mstep(model_t m, int n, bit t, logic [1:0] md,
                                     bit st, bit we, logic [7:0] wa, logic [2:0] wd);
        int period = t ? DT : DN;
        bit req    = (md != 2'b00) && (m.cnt >= period - 1);
        bit adv    = st || req;
        int delta;
        m.cnt = (md == 2'b00 || adv) ? 0 : m.cnt + 1;
        if (adv && n > 1) begin
            if (md == 2'b10) begin
                if (m.dir_up && m.idx == n - 1) m.dir_up = 1'b0;
                else if (!m.dir_up && m.idx == 0) m.dir_up = 1'b1;
                delta = m.dir_up ? 1 : -1;
            end else begin
                delta = (md == 2'b11) ? -1 : 1;
            end
            m.idx = (m.idx + delta + n) % n;
        end
        if (we && int'(wa) < n) m.pal[wa[2:0]] = wd;
        m.rgb  = m.pal[m.idx[2:0]];
        m.tick = adv;
        return m;
    endfunction

    task automatic drive(input bit r, input bit t, input logic [1:0] md, input bit st,
                         input bit we, input logic [7:0] wa, input logic [2:0] wd);
        @(negedge clk);
        rst_n = r; turbo = t; mode = md; step = st;
        wr_en = we; wr_addr = wa; wr_data = wd;
        if (!r) begin
            m8 = mreset();
            m1 = mreset();
        end else begin
            m8 = mstep(m8, 8, t, md, st, we, wa, wd);
            m1 = mstep(m1, 1, t, md, st, we, wa, wd);
        end
        q8.push_back(m8);
        q1.push_back(m1);
    endtask

    initial begin : monitor
        model_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q8.size() != 0) begin
                e = q8.pop_front();
                chk("idx8", int'(idx8), e.idx);
                chk("rgb8", int'(rgb8), int'(e.rgb));
                chk("tick8", int'(tick8), int'(e.tick));
            end
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("idx1", int'(idx1), e.idx);
                chk("rgb1", int'(rgb1), int'(e.rgb));
                chk("tick1", int'(tick1), int'(e.tick));
            end
        end
    end

    initial begin : stim
        bit         t, st, we;
        logic [1:0] md;
        int         guard;
        rst_n = 1'b0; turbo = 1'b0; mode = 2'b00; step = 1'b0;
        wr_en = 1'b0; wr_addr = 8'd0; wr_data = 3'd0;
        m8 = mreset();
        m1 = mreset();

        repeat (2) drive(0, 0, 2'b00, 0, 0, 8'd0, 3'd0);
        chk("rst_idx", int'(idx8), 0);
        chk("rst_rgb", int'(rgb8), 0);
        chk("rst_tick", int'(tick8), 0);

        // cycle up at normal speed
        repeat (20) drive(1, 0, 2'b01, 0, 0, 8'd0, 3'd0);

        // ping-pong from idx 5 through both turnarounds; N_COL=1 ignores addr 3
        guard = 0;
        while (m8.idx != 5 && guard < 64) begin
            drive(1, 0, 2'b01, 0, 0, 8'd0, 3'd0);
            guard++;
        end
        chk("reach_idx5", m8.idx, 5);
        drive(1, 0, 2'b10, 0, 1, 8'd3, 3'd6);
        repeat (60) drive(1, 0, 2'b10, 0, 0, 8'd0, 3'd0);

        // turbo switch while the prescaler sits at 3
        guard = 0;
        while (m8.cnt != 3 && guard < 16) begin
            drive(1, 0, 2'b01, 0, 0, 8'd0, 3'd0);
            guard++;
        end
        chk("reach_cnt3", m8.cnt, 3);
        repeat (10) drive(1, 1, 2'b01, 0, 0, 8'd0, 3'd0);
        repeat (12) drive(1, 0, 2'b01, 0, 0, 8'd0, 3'd0);

        // hold mode: three steps, the second with a write-through to the next entry
        repeat (6) drive(1, 0, 2'b00, 0, 0, 8'd0, 3'd0);
        drive(1, 0, 2'b00, 1, 0, 8'd0, 3'd0);
        repeat (3) drive(1, 0, 2'b00, 0, 0, 8'd0, 3'd0);
        drive(1, 0, 2'b00, 1, 1, 8'((m8.idx + 1) % 8), 3'b101);
        repeat (3) drive(1, 0, 2'b00, 0, 0, 8'd0, 3'd0);
        drive(1, 0, 2'b00, 1, 0, 8'd0, 3'd0);
        repeat (6) drive(1, 0, 2'b00, 0, 0, 8'd0, 3'd0);

        // reset mid-count at idx 6
        guard = 0;
        while (!(m8.idx == 6 && m8.cnt == 2) && guard < 80) begin
            drive(1, 0, 2'b01, 0, 0, 8'd0, 3'd0);
            guard++;
        end
        chk("reach_idx6", m8.idx, 6);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_idx", int'(idx8), 0);
        chk("midrst_rgb", int'(rgb8), 0);
        chk("midrst_tick", int'(tick8), 0);
        repeat (2) drive(0, 0, 2'b01, 0, 1, 8'd2, 3'd7);
        repeat (10) drive(1, 0, 2'b01, 0, 0, 8'd0, 3'd0);

        // randomized traffic
        t = 0;
        md = 2'b01;
        for (int n = 0; n < 700; n++) begin
            if ($urandom_range(0, 29) == 0) t = ~t;
            if ($urandom_range(0, 24) == 0) md = 2'($urandom_range(0, 3));
            st = ($urandom_range(0, 11) == 0);
            we = ($urandom_range(0, 5) == 0);
            drive(($urandom_range(0, 199) != 0), t, md, st, we,
                  8'($urandom_range(0, 11)), 3'($urandom_range(0, 7)));
        end

        drive(1, 0, 2'b00, 0, 0, 8'd0, 3'd0);
        @(posedge clk);
        #3;
        chk("drain", q8.size() + q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
